rou_mng_dispatch: RTL



---
 rtl/rou_mng_dispatch.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rou_mng_dispatch.sv
// Management-message dispatcher for the roubus message path: classifies each
// accepted message, applies node-local ID/counter actions, and forwards it through one register stage.
module rou_mng_dispatch #(
  parameter int          DWID = 128,
  parameter int          AWID = 32,
  parameter int          TWID = 5,
  parameter int          BWID = (DWID == 512) ? 6 :
                                (DWID == 256) ? 5 :
                                (DWID == 128) ? 4 :
                                (DWID == 64)  ? 3 : 2,
  parameter int          WID  = 2 + DWID + AWID + BWID + TWID,
  parameter int          IDW  = 8,
  parameter int          CNTW = 16,
  parameter logic [31:0] LEGAL = 32'h0000_00FF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WID-1:0]  in_msg,
  input  logic            in_vld,
  output logic            in_rdy,
  output logic [WID-1:0]  out_msg,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [2:0]      out_kind,
  output logic [IDW-1:0]  my_id,
  output logic            id_valid,
  output logic [CNTW-1:0] mng_cnt,
  output logic [CNTW-1:0] bad_cnt,
  input  logic            clr_cnt
);

  typedef enum logic [2:0] {
    K_DATA   = 3'd0,
    K_RESET  = 3'd1,
    K_ENUM   = 3'd2,
    K_CTRL   = 3'd3,
    K_REPORT = 3'd4,
    K_OREQ   = 3'd5,
    K_ORSP   = 3'd6
  } kind_e;

  logic [WID-1:0]  out_msg_q, out_msg_d;
  logic            out_vld_q, out_vld_d;
  kind_e           out_kind_q, out_kind_d;
  logic [IDW-1:0]  my_id_q, my_id_d;
  logic            id_valid_q, id_valid_d;
  logic [CNTW-1:0] mng_cnt_q, mng_cnt_d;
  logic [CNTW-1:0] bad_cnt_q, bad_cnt_d;

  logic [1:0]      cmd;
  logic [TWID-1:0] tag;
  logic [31:0]     legal_sh;
  logic            is_mng;
  logic            bad;
  logic            accept;
  kind_e           kind;

  assign cmd      = in_msg[WID-1 -: 2];
  assign tag      = in_msg[WID-3 -: TWID];
  assign is_mng   = (cmd == 2'b11);
  // Shifting by a tag beyond bit 31 yields 0, so out-of-range tags are illegal.
  assign legal_sh = LEGAL >> tag;
  assign bad      = is_mng && !legal_sh[0];
  assign in_rdy   = !out_vld_q || out_rdy;
  assign accept   = in_vld && in_rdy;

  always_comb begin
    kind = K_DATA;
    if (is_mng) begin
      if (tag[0])                   kind = K_ORSP;
      else if (tag == TWID'(0))     kind = K_RESET;
      else if (tag == TWID'(2))     kind = K_ENUM;
      else if (tag == TWID'(4))     kind = K_CTRL;
      else if (tag == TWID'(6))     kind = K_REPORT;
      else                          kind = K_OREQ;
    end
  end

  always_comb begin
    out_msg_d  = out_msg_q;
    out_vld_d  = out_vld_q;
    out_kind_d = out_kind_q;
    my_id_d    = my_id_q;
    id_valid_d = id_valid_q;
    mng_cnt_d  = mng_cnt_q;
    bad_cnt_d  = bad_cnt_q;

    if (accept && !bad) begin
      out_msg_d  = in_msg;
      out_vld_d  = 1'b1;
      out_kind_d = kind;
      if (kind == K_ENUM && !id_valid_q) begin
        my_id_d                = in_msg[IDW-1:0];
        id_valid_d             = 1'b1;
        out_msg_d[IDW-1:0]     = in_msg[IDW-1:0] + IDW'(1);
      end
      if (kind == K_RESET) begin
        my_id_d    = '0;
        id_valid_d = 1'b0;
      end
    end else if (out_rdy) begin
      // Covers both a plain drain and a bad message dropped while draining.
      out_vld_d = 1'b0;
    end

    if (accept && is_mng && mng_cnt_q != {CNTW{1'b1}}) mng_cnt_d = mng_cnt_q + CNTW'(1);
    if (accept && bad    && bad_cnt_q != {CNTW{1'b1}}) bad_cnt_d = bad_cnt_q + CNTW'(1);
    if (clr_cnt) begin
      mng_cnt_d = '0;
      bad_cnt_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments and reset asynchronously,
  // so an in-flight output is discarded the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_msg_q  <= '0;
      out_vld_q  <= 1'b0;
      out_kind_q <= K_DATA;
      my_id_q    <= '0;
      id_valid_q <= 1'b0;
      mng_cnt_q  <= '0;
      bad_cnt_q  <= '0;
    end else begin
      out_msg_q  <= out_msg_d;
      out_vld_q  <= out_vld_d;
      out_kind_q <= out_kind_d;
      my_id_q    <= my_id_d;
      id_valid_q <= id_valid_d;
      mng_cnt_q  <= mng_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign out_msg  = out_msg_q;
  assign out_vld  = out_vld_q;
  assign out_kind = out_kind_q;
  assign my_id    = my_id_q;
  assign id_valid = id_valid_q;
  assign mng_cnt  = mng_cnt_q;
  assign bad_cnt  = bad_cnt_q;

endmodule
